// File: rtl/async_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer logic.
// Gray/binary helpers operate on MAX_PTR_W-bit vectors; narrower pointers
// are zero-extended on the way in and truncated on the way out, which is
// exact for both conversions because leading zeros map to leading zeros.
package async_fifo_pkg;

    localparam int unsigned MAX_PTR_W  = 13;
    localparam int unsigned MIN_ADDR_W = 2;
    localparam int unsigned MAX_ADDR_W = MAX_PTR_W - 1;
    localparam int unsigned DROP_CNT_W = 8;

    // Binary to reflected Gray code.
    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary: prefix XOR from the MSB down.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : async_fifo_pkg

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter, width-parameterised.
// Shared by the write-side and read-side FIFO controllers.
module gray2bin_conv
    import async_fifo_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    logic [MAX_PTR_W-1:0] w_gray_ext;
    logic [MAX_PTR_W-1:0] w_bin_ext;

    // Widen to the package width, convert, then narrow back.
    always_comb begin
        w_gray_ext = MAX_PTR_W'(i_gray);
        w_bin_ext  = gray2bin(w_gray_ext);
        o_bin      = W'(w_bin_ext);
    end

endmodule : gray2bin_conv

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO (write clock domain only).
// Owns the binary/Gray write pointer, drives the RAM write port
// combinationally, and derives full, almost_full, a conservative fill level
// and a sticky overflow flag from the synchronized read pointer.
// Optional: define ASYNC_FIFO_WR_DROP_CNT_EN to add an 8-bit saturating
// counter of dropped writes (drop_cnt).
module async_fifo_wr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   rd_ptr_gray_sync,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic              ovf_clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
`ifdef ASYNC_FIFO_WR_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    // Registered state
    logic [PTR_W-1:0] r_wr_bin;
    logic [PTR_W-1:0] r_wr_gray;
    logic             r_full;
    logic             r_almost_full;
    logic [PTR_W-1:0] r_wr_level;
    logic             r_overflow;

    // Next-state and helper nets
    logic             w_push;
    logic             w_drop;
    logic [PTR_W-1:0] w_wr_bin_next;
    logic [PTR_W-1:0] w_wr_gray_next;
    logic [PTR_W-1:0] w_rd_bin;
    logic [PTR_W-1:0] w_rd_gray_full;
    logic [PTR_W-1:0] w_level_next;
    logic             w_full_next;
    logic             w_almost_full_next;
    logic             w_overflow_next;

    // Read pointer back to binary for level arithmetic.
    gray2bin_conv #(
        .W (PTR_W)
    ) u_rd_g2b (
        .i_gray (rd_ptr_gray_sync),
        .o_bin  (w_rd_bin)
    );

    // Accept/drop decision and pointer/flag next-state computation.
    always_comb begin
        w_push = wr_en & ~r_full;
        w_drop = wr_en & r_full;

        w_wr_bin_next  = r_wr_bin + PTR_W'(w_push);
        w_wr_gray_next = PTR_W'(bin2gray(MAX_PTR_W'(w_wr_bin_next)));

        // Full when the write pointer is exactly one lap ahead: in Gray code
        // that means the top two bits are inverted and the rest are equal.
        w_rd_gray_full = {~rd_ptr_gray_sync[ADDR_W:ADDR_W-1], rd_ptr_gray_sync[ADDR_W-2:0]};
        w_full_next    = (w_wr_gray_next == w_rd_gray_full);

        // Stale read pointer can only make this look fuller than reality.
        w_level_next       = w_wr_bin_next - w_rd_bin;
        w_almost_full_next = (w_level_next >= af_thresh);

        // A new drop beats a simultaneous clear.
        w_overflow_next = (r_overflow & ~ovf_clr) | w_drop;
    end

    // RAM write port: captured by the RAM on the same clk edge.
    always_comb begin
        mem_we    = w_push;
        mem_waddr = r_wr_bin[ADDR_W-1:0];
        mem_wdata = wr_data;
    end

    // Pointer and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bin      <= '0;
            r_wr_gray     <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_wr_level    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_wr_bin      <= w_wr_bin_next;
            r_wr_gray     <= w_wr_gray_next;
            r_full        <= w_full_next;
            r_almost_full <= w_almost_full_next;
            r_wr_level    <= w_level_next;
            r_overflow    <= w_overflow_next;
        end
    end

    assign wr_ptr_gray = r_wr_gray;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign wr_level    = r_wr_level;
    assign overflow    = r_overflow;

`ifdef ASYNC_FIFO_WR_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // Saturating dropped-write counter; a drop in the clear cycle leaves 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            if (ovf_clr) begin
                r_drop_cnt <= DROP_CNT_W'(1);
            end else if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
        end else if (ovf_clr) begin
            r_drop_cnt <= '0;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule : async_fifo_wr_ctrl
